// File: rtl/nebula_mem_arbiter.sv
// -----------------------------------------------------------------------------
// nebula_mem_arbiter
//
// Purpose:
//   Arbitrates NUM_PORTS requesting channels onto a single downstream memory
//   port. One transaction is outstanding at a time. The winner's we/addr/wdata
//   are captured at grant and presented to memory from registers, so a port's
//   live inputs never reach the memory side directly.
//
// Parameters:
//   NUM_PORTS      number of requesting channels (2..8)
//   ADDR_WIDTH     physical address width
//   DATA_WIDTH     cache-line data width
//   ARB_MODE       0 = fixed priority (port 0 highest), 1 = round-robin
//   TIMEOUT_CYCLES watchdog limit (only with NEBULA_ARB_TIMEOUT_EN)
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   port_req/we/addr/wdata       per-port request level and payload (flattened,
//                                port i occupies slice i)
//   port_ack/port_error          one-hot completion / error pulses
//   port_rdata                   shared read data, valid with port_ack
//   mem_req/we/addr/wdata        downstream request (held through BUSY)
//   mem_ack/mem_error/mem_rdata  downstream completion
//   grant_id                     current or last granted port
//   busy                         high while a transaction is outstanding;
//                                this is also the FSM state (IDLE=0, BUSY=1)
//
// Handshake: a port raises port_req and holds req/we/addr/wdata stable until
// it sees port_ack or port_error; the arbiter holds mem_req high from grant
// until mem_ack or mem_error, and the completion is forwarded combinationally
// in that same cycle.
//
// Build option:
//   `define NEBULA_ARB_TIMEOUT_EN  adds a watchdog that errors out a
//                                  transaction after TIMEOUT_CYCLES.
// -----------------------------------------------------------------------------
module nebula_mem_arbiter #(
    parameter int NUM_PORTS      = 3,
    parameter int ADDR_WIDTH     = 56,
    parameter int DATA_WIDTH     = 512,
    parameter int ARB_MODE       = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             port_req,
    input  logic [NUM_PORTS-1:0]             port_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata,
    output logic [NUM_PORTS-1:0]             port_ack,
    output logic [NUM_PORTS-1:0]             port_error,
    output logic [DATA_WIDTH-1:0]            port_rdata,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic                             mem_ack,
    input  logic                             mem_error,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic [$clog2(NUM_PORTS)-1:0]     grant_id,
    output logic                             busy
);

    localparam int IDW = $clog2(NUM_PORTS);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDW-1:0]          r_grant_id;
    logic [IDW-1:0]          r_rr_ptr;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;

    logic [IDW-1:0]          w_winner;
    logic [IDW-1:0]          w_idx;
    logic                    w_found;
    logic                    w_grant;
    logic                    w_busy;
    logic                    w_timeout;
    logic                    w_err;
    logic                    w_ack;
    logic                    w_done;
    logic [NUM_PORTS-1:0]    w_onehot;

    assign w_busy  = (r_state == S_BUSY);
    assign w_grant = (r_state == S_IDLE) && (|port_req);

    // Winner search. Fixed priority scans from port 0; round-robin scans
    // cyclically starting at r_rr_ptr. The first requester found wins.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (ARB_MODE == 0) begin
                w_idx = IDW'(i);
            end else begin
                w_idx = IDW'((int'(r_rr_ptr) + i) % NUM_PORTS);
            end
            if (!w_found && port_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

`ifdef NEBULA_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] r_wdog;

    // Held at zero in IDLE so it starts from zero on entering BUSY; counts
    // every BUSY cycle that does not complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if (!w_busy) begin
            r_wdog <= '0;
        end else if (!w_done) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign w_timeout = w_busy && (r_wdog == WDW'(TIMEOUT_CYCLES));
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // Error beats ack when both arrive together; a watchdog expiry is an error.
    assign w_err    = w_busy && (mem_error || w_timeout);
    assign w_ack    = w_busy && mem_ack && !w_err;
    assign w_done   = w_err || w_ack;
    assign w_onehot = NUM_PORTS'(1) << r_grant_id;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_done)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_grant_id <= w_winner;
                r_we       <= port_we[w_winner];
                r_addr     <= port_addr[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
                r_wdata    <= port_wdata[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (w_done) begin
                r_rr_ptr <= (r_grant_id == IDW'(NUM_PORTS - 1)) ? '0 : r_grant_id + 1'b1;
            end
        end
    end

    assign mem_req    = w_busy;
    assign busy       = w_busy;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign grant_id   = r_grant_id;
    assign port_ack   = w_ack ? w_onehot : '0;
    assign port_error = w_err ? w_onehot : '0;
    assign port_rdata = w_busy ? mem_rdata : '0;

endmodule

// File: tb/tb_nebula_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nebula_mem_arbiter
//
// Two arbiter instances: a round-robin one (main) and a fixed-priority one
// (f_*). Directed steps cover reset, single request, round-robin order,
// simultaneous ack+error, completions in IDLE, reset mid-transaction and
// fixed priority; a randomized phase follows, checked against a reference
// model that picks the winner as "first requester at or after the pointer".
// -----------------------------------------------------------------------------
module tb_nebula_mem_arbiter;

    localparam int NP = 3;
    localparam int AW = 56;
    localparam int DW = 512;
    localparam int IW = $clog2(NP);

    logic              clk;
    logic              rst_n;

    logic [NP-1:0]     port_req;
    logic [NP-1:0]     port_we;
    logic [NP*AW-1:0]  port_addr;
    logic [NP*DW-1:0]  port_wdata;
    logic [NP-1:0]     port_ack;
    logic [NP-1:0]     port_error;
    logic [DW-1:0]     port_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_ack;
    logic              mem_error;
    logic [DW-1:0]     mem_rdata;
    logic [IW-1:0]     grant_id;
    logic              busy;

    logic [NP-1:0]     f_req;
    logic [NP-1:0]     f_we;
    logic [NP*AW-1:0]  f_addr;
    logic [NP*DW-1:0]  f_wdata;
    logic [NP-1:0]     f_port_ack;
    logic [NP-1:0]     f_port_error;
    logic [DW-1:0]     f_port_rdata;
    logic              f_mem_req;
    logic              f_mem_we;
    logic [AW-1:0]     f_mem_addr;
    logic [DW-1:0]     f_mem_wdata;
    logic              f_mem_ack;
    logic              f_mem_error;
    logic [DW-1:0]     f_mem_rdata;
    logic [IW-1:0]     f_grant_id;
    logic              f_busy;

    nebula_mem_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .ARB_MODE(1), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .port_req(port_req), .port_we(port_we),
        .port_addr(port_addr), .port_wdata(port_wdata),
        .port_ack(port_ack), .port_error(port_error), .port_rdata(port_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_error(mem_error), .mem_rdata(mem_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    nebula_mem_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .ARB_MODE(0), .TIMEOUT_CYCLES(16)
    ) dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .port_req(f_req), .port_we(f_we),
        .port_addr(f_addr), .port_wdata(f_wdata),
        .port_ack(f_port_ack), .port_error(f_port_error), .port_rdata(f_port_rdata),
        .mem_req(f_mem_req), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_ack(f_mem_ack), .mem_error(f_mem_error), .mem_rdata(f_mem_rdata),
        .grant_id(f_grant_id), .busy(f_busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- bench state / model ----------------
    int               n_tests = 0;
    int               n_fail  = 0;
    int               rr_ptr_m;
    logic [NP-1:0]    a_req;
    logic [NP-1:0]    a_we;
    logic [AW-1:0]    a_addr [NP];
    logic [DW-1:0]    a_wdata[NP];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [NP-1:0] oh(input int i);
        logic [NP-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Round-robin reference: first requester at or after the pointer, cyclic.
    function automatic int rr_winner(input logic [NP-1:0] mask);
        for (int i = 0; i < NP; i++) begin
            if (mask[(rr_ptr_m + i) % NP]) return (rr_ptr_m + i) % NP;
        end
        return -1;
    endfunction

    // Fixed-priority reference: lowest-index requester.
    function automatic int low_winner(input logic [NP-1:0] mask);
        for (int i = 0; i < NP; i++) if (mask[i]) return i;
        return -1;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_ports();
        port_req = a_req;
        port_we  = a_we;
        for (int p = 0; p < NP; p++) begin
            port_addr[p*AW +: AW]  = a_addr[p];
            port_wdata[p*DW +: DW] = a_wdata[p];
        end
    endtask

    task automatic new_payload(input int p);
        a_we[p]    = 1'($urandom_range(0, 1));
        a_addr[p]  = {$urandom, $urandom};
        a_wdata[p] = rand_line();
    endtask

    // Entered at a negedge in IDLE with requests already driven. Checks the
    // grant, holds for wait_cyc cycles, completes (kind 0=ack, 1=error,
    // 2=ack+error) and returns at the negedge after the FSM is back in IDLE.
    task automatic do_txn(input int exp_w, input int wait_cyc, input int kind,
                          input logic [DW-1:0] rd, input bit drop);
        logic [NP-1:0] e_ack;
        logic [NP-1:0] e_err;
        @(posedge clk); @(negedge clk);
        chk("mem_req_rise", mem_req, 1'b1);
        chk("busy_high", busy, 1'b1);
        chk("grant_id", grant_id, exp_w);
        chk("mem_addr", mem_addr, a_addr[exp_w]);
        chk("mem_we", mem_we, a_we[exp_w]);
        chk("mem_wdata", mem_wdata, a_wdata[exp_w]);
        if (drop) begin
            a_req[exp_w] = 1'b0;
            drive_ports();
        end
        for (int k = 0; k < wait_cyc; k++) begin
            chk("no_early_done", port_ack | port_error, '0);
            @(posedge clk); @(negedge clk);
            chk("mem_req_hold", mem_req, 1'b1);
        end
        mem_rdata = rd;
        mem_ack   = (kind != 1);
        mem_error = (kind != 0);
        #1;
        e_ack = (kind == 0) ? oh(exp_w) : '0;
        e_err = (kind != 0) ? oh(exp_w) : '0;
        chk("port_ack", port_ack, e_ack);
        chk("port_error", port_error, e_err);
        chk("port_rdata", port_rdata, rd);
        @(posedge clk);
        rr_ptr_m = (exp_w + 1) % NP;
        @(negedge clk);
        mem_ack      = 1'b0;
        mem_error    = 1'b0;
        a_req[exp_w] = 1'b0;
        drive_ports();
        chk("idle_after_done", busy, 1'b0);
        chk("mem_req_low", mem_req, 1'b0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int rr_exp[4];
        int w;
        int kind;
        logic [NP-1:0] f_exp_ack;

        rr_exp    = '{0, 1, 2, 0};
        rst_n     = 1'b0;
        a_req     = '0;
        a_we      = '0;
        for (int p = 0; p < NP; p++) new_payload(p);
        drive_ports();
        mem_ack   = 1'b1;
        mem_error = 1'b0;
        mem_rdata = rand_line();
        f_req = '0; f_we = '0; f_addr = '0; f_wdata = '0;
        f_mem_ack = 1'b0; f_mem_error = 1'b0; f_mem_rdata = '0;
        rr_ptr_m  = 0;

        // Reset values (mem_ack driven high to show it is not forwarded).
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, '0);
        chk("rst_port_ack", port_ack, '0);
        chk("rst_port_error", port_error, '0);
        chk("rst_port_rdata", port_rdata, '0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_wdata", mem_wdata, '0);
        mem_ack = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);

        // Round-robin fairness with all ports requesting continuously.
        for (int j = 0; j < 4; j++) begin
            a_req = 3'b111;
            drive_ports();
            chk("rr_model", rr_winner(a_req), rr_exp[j]);
            do_txn(rr_exp[j], 1, 0, rand_line(), 1'b0);
        end

        // Single request on port 1, read, ack after a few cycles.
        a_req     = 3'b010;
        a_addr[1] = 56'h1000;
        a_we[1]   = 1'b0;
        drive_ports();
        #1;
        chk("pre_grant_mem_req", mem_req, 1'b0);
        do_txn(1, 3, 0, {64{8'hA5}}, 1'b0);

        // Simultaneous ack + error on port 2.
        a_req = 3'b100;
        new_payload(2);
        drive_ports();
        do_txn(2, 2, 2, rand_line(), 1'b0);

        // Completions arriving in IDLE are ignored.
        mem_ack   = 1'b1;
        mem_error = 1'b1;
        #1;
        chk("idle_ack_ignored", port_ack, '0);
        chk("idle_err_ignored", port_error, '0);
        @(posedge clk); @(negedge clk);
        chk("idle_stays_idle", busy, 1'b0);
        mem_ack   = 1'b0;
        mem_error = 1'b0;

        // Port 0 alone, moves the pointer to 1.
        a_req = 3'b001;
        new_payload(0);
        drive_ports();
        do_txn(0, 0, 0, rand_line(), 1'b0);

        // Reset in the 2nd BUSY cycle of a grant to port 1.
        a_req = 3'b111;
        drive_ports();
        w = rr_winner(a_req);
        chk("rr_model_pre_rst", w, 1);
        @(posedge clk); @(negedge clk);
        chk("grant_pre_rst", grant_id, 1);
        @(posedge clk); @(negedge clk);
        mem_ack = 1'b1;
        rst_n   = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_port_ack", port_ack, '0);
        chk("midrst_port_error", port_error, '0);
        chk("midrst_grant_id", grant_id, '0);
        chk("midrst_mem_addr", mem_addr, '0);
        @(negedge clk);
        mem_ack  = 1'b0;
        rst_n    = 1'b1;
        rr_ptr_m = 0;
        do_txn(0, 1, 0, rand_line(), 1'b0);
        a_req = '0;
        drive_ports();

        // Randomized phase.
        for (int t = 0; t < 40; t++) begin
            for (int p = 0; p < NP; p++) begin
                if (!a_req[p] && $urandom_range(0, 1) == 1) begin
                    a_req[p] = 1'b1;
                    new_payload(p);
                end
            end
            drive_ports();
            if (a_req == '0) begin
                mem_ack = 1'b1;
                #1;
                chk("rand_idle_ack", port_ack, '0);
                @(posedge clk); @(negedge clk);
                chk("rand_idle_busy", busy, 1'b0);
                mem_ack = 1'b0;
            end else begin
                kind = int'($urandom_range(0, 3));
                kind = (kind < 2) ? 0 : kind - 1;
                do_txn(rr_winner(a_req), int'($urandom_range(0, 4)), kind, rand_line(),
                       ($urandom_range(0, 3) == 0));
            end
        end
        a_req = '0;
        drive_ports();
        @(negedge clk);

        // Fixed priority: ports 0 and 2 request; port 2 only after 0 drops.
        for (int p = 0; p < NP; p++) begin
            f_addr[p*AW +: AW] = {$urandom, $urandom};
            f_wdata[p*DW +: DW] = rand_line();
        end
        f_req = 3'b101;
        for (int j = 0; j < 4; j++) begin
            if (j == 3) f_req = 3'b100;
            w = low_winner(f_req);
            @(posedge clk); @(negedge clk);
            chk("fixed_busy", f_busy, 1'b1);
            chk("fixed_grant", f_grant_id, w);
            chk("fixed_addr", f_mem_addr, f_addr[w*AW +: AW]);
            f_mem_ack   = 1'b1;
            f_mem_rdata = rand_line();
            #1;
            f_exp_ack = oh(w);
            chk("fixed_ack", f_port_ack, f_exp_ack);
            @(posedge clk); @(negedge clk);
            f_mem_ack = 1'b0;
            chk("fixed_idle", f_busy, 1'b0);
        end
        f_req = '0;
        chk("fixed_port2_last", w, 2);

`ifdef NEBULA_ARB_TIMEOUT_EN
        // Watchdog: no completion ever returned.
        a_req = 3'b010;
        new_payload(1);
        drive_ports();
        w = rr_winner(a_req);
        @(posedge clk); @(negedge clk);
        for (int c = 1; c <= 16; c++) begin
            chk("wd_no_err_yet", port_error, '0);
            chk("wd_mem_req", mem_req, 1'b1);
            @(posedge clk); @(negedge clk);
        end
        chk("wd_error_pulse", port_error, oh(w));
        chk("wd_no_ack", port_ack, '0);
        a_req = '0;
        drive_ports();
        @(posedge clk);
        rr_ptr_m = (w + 1) % NP;
        @(negedge clk);
        chk("wd_idle", mem_req, 1'b0);
        chk("wd_err_single", port_error, '0);
        repeat (2) @(negedge clk);
        mem_ack = 1'b1;
        #1;
        chk("wd_late_ack", port_ack, '0);
        @(negedge clk);
        mem_ack = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nebula_mem_arbiter.md
NEBULA_MEM_ARBITER -- requirements
Module: nebula_mem_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 3, number of requesting channels, legal range 2..8.
REQ-002 Parameter ADDR_WIDTH, default 56, physical address width.
REQ-003 Parameter DATA_WIDTH, default 512, cache-line data width.
REQ-004 Parameter ARB_MODE, default 1: 0 = fixed priority with port 0 highest; 1 = round-robin.
REQ-005 Parameter TIMEOUT_CYCLES, default 1024, watchdog limit; used only under NEBULA_ARB_TIMEOUT_EN.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 port_req  input  NUM_PORTS  per-port request level.
REQ-009 port_we  input  NUM_PORTS  per-port write enable.
REQ-010 port_addr  input  NUM_PORTS*ADDR_WIDTH  flattened addresses; port i occupies slice i.
REQ-011 port_wdata  input  NUM_PORTS*DATA_WIDTH  flattened write data.
REQ-012 port_ack  output  NUM_PORTS  one-hot completion pulse.
REQ-013 port_error  output  NUM_PORTS  one-hot error pulse.
REQ-014 port_rdata  output  DATA_WIDTH  shared read data, valid with port_ack.
REQ-015 mem_req, mem_we  output  1 each  downstream request and write enable.
REQ-016 mem_addr  output  ADDR_WIDTH; mem_wdata  output  DATA_WIDTH.
REQ-017 mem_ack, mem_error  input  1 each; mem_rdata  input  DATA_WIDTH.
REQ-018 grant_id  output  $clog2(NUM_PORTS)  index of the current or last granted port.
REQ-019 busy  output  1  high while in BUSY.

Function
REQ-020 Ports SHALL hold port_req, port_we, port_addr and port_wdata stable from assertion until port_ack or port_error is seen; a new request may follow at the next edge.
REQ-021 The FSM SHALL have two states, IDLE and BUSY.
- IDLE: if any port_req is set, pick a winner, register grant_id together with that port's we/addr/wdata, and enter BUSY at the next edge.
REQ-022 mem_req SHALL be high throughout BUSY and low in IDLE; minimum latency is 1 cycle from port_req to mem_req.
REQ-023 mem_we, mem_addr and mem_wdata SHALL come from registered copies captured at grant, not from live port inputs.
REQ-024 In BUSY, mem_ack or mem_error SHALL combinationally assert port_ack[grant_id] or port_error[grant_id] in the same cycle, with port_rdata = mem_rdata, and the FSM returns to IDLE at the next edge.
REQ-025 If mem_ack and mem_error are asserted together, port_error SHALL win and port_ack SHALL stay low.
REQ-026 Round-robin SHALL search starting at pointer rr_ptr. On each completion, rr_ptr = (grant_id+1) mod NUM_PORTS, wrapping from NUM_PORTS-1 to 0.
REQ-027 Fixed priority SHALL grant the lowest-index requester; rr_ptr is unused.
REQ-028 Only one transaction SHALL be outstanding. Requests arriving in BUSY wait, and port_req dropping in BUSY SHALL NOT abort the transaction.
REQ-029 mem_ack and mem_error received in IDLE SHALL be ignored, and all port_ack and port_error bits SHALL stay 0.
REQ-030 port_ack and port_error SHALL be 0 for every port other than grant_id, and 0 outside BUSY.

Reset
REQ-031 Asserting rst_n low SHALL immediately force the following, including mid-transaction, with no completion pulse issued:
- FSM to IDLE;
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
- port_ack=0, port_error=0, port_rdata=0;
- grant_id=0, rr_ptr=0, busy=0, watchdog=0.
REQ-032 The first arbitration after reset release SHALL start from port 0.

Configuration
REQ-033 When macro NEBULA_ARB_TIMEOUT_EN is defined, the watchdog SHALL behave as follows:
- a counter clears on entering BUSY and increments each BUSY cycle without mem_ack or mem_error;
- on reaching TIMEOUT_CYCLES, port_error[grant_id] pulses for one cycle, mem_req drops and the FSM returns to IDLE;
- rr_ptr updates as for a normal completion;
- a late mem_ack is then ignored per REQ-029.
REQ-034 Without NEBULA_ARB_TIMEOUT_EN, no watchdog logic SHALL exist and BUSY SHALL wait indefinitely for mem_ack or mem_error.

Verification
REQ-035 Single request:
- stimulus: port_req=3'b010, addr=0x1000, we=0; mem_ack after 4 cycles with rdata=0xA5..;
- response: mem_req rises 1 cycle after port_req, mem_addr=0x1000, port_ack=3'b010 with port_rdata=0xA5.. in the mem_ack cycle, grant_id=1.
REQ-036 Round-robin fairness (ARB_MODE=1):
- stimulus: ports 0, 1 and 2 all requesting continuously after reset;
- response: grant order 0, 1, 2, 0; no port is granted twice before every other port is granted once.
REQ-037 Fixed priority (ARB_MODE=0):
- stimulus: ports 0 and 2 requesting continuously;
- response: port 0 is always granted; port 2 is granted only after port 0 deasserts.
REQ-038 Simultaneous completion:
- stimulus: mem_ack=1 and mem_error=1 in the same cycle;
- response: port_error[grant_id]=1, port_ack all 0, FSM in IDLE next cycle.
REQ-039 Timeout (macro defined, TIMEOUT_CYCLES=16):
- stimulus: no mem_ack is ever returned;
- response: port_error pulses exactly 16 BUSY cycles after mem_req rises; a mem_ack arriving 3 cycles later produces no port_ack.
REQ-040 Reset mid-transaction:
- stimulus: rst_n driven low in the 2nd BUSY cycle;
- response: mem_req=0 asynchronously with no ack pulse; the first grant after release goes to port 0.
